// File: rtl/ts_pkg.sv
// ts_pkg: shared MPEG-TS constants, PCR field widths and the PCR reader FSM encoding.
package ts_pkg;

  localparam int unsigned TS_PKT_LEN     = 188;
  localparam logic [7:0]  TS_SYNC_BYTE   = 8'h47;

  // Byte offsets within a TS packet (sync byte is offset 0)
  localparam int unsigned PID_HI         = 1;
  localparam int unsigned PID_LO         = 2;
  localparam int unsigned AFC            = 3;
  localparam int unsigned AF_LEN         = 4;
  localparam int unsigned AF_FLAGS       = 5;
  localparam int unsigned PCR_FIRST      = 6;
  localparam int unsigned PCR_LAST       = 11;

  // Shortest adaptation field that can hold flags + a 6-byte PCR
  localparam int unsigned PCR_AF_MIN_LEN = 7;

  localparam int unsigned PCR_EXT_MAX    = 299;
  localparam int unsigned PCR_BASE_W     = 33;
  localparam int unsigned PCR_EXT_W      = 9;
  localparam int unsigned PCR_W          = PCR_BASE_W + PCR_EXT_W;
  localparam int unsigned PID_W          = 13;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    AF,
    PCR,
    SKIP
  } pcr_state_t;

endpackage

// File: rtl/pcr_extract_if.sv
// pcr_extract_if: TS byte stream in, PID filter config, extracted PCR/stamp out.
//   master: drives ts_sync/ts_valid/ts_data/cfg_pid/cfg_pid_en, observes results
//   slave : the PCR reader
interface pcr_extract_if;
  import ts_pkg::*;

  logic                 ts_sync;
  logic                 ts_valid;
  logic [7:0]           ts_data;
  logic [PID_W-1:0]     cfg_pid;
  logic                 cfg_pid_en;

  logic                 pcr_o_valid;
  logic [PCR_W-1:0]     pcr_o_data;
  logic [PID_W-1:0]     pcr_o_pid;
  logic                 pcr_o_disc;
  logic [PCR_W-1:0]     pcr_o_stamp;
  logic                 sync_err;

  modport master (
    output ts_sync, ts_valid, ts_data, cfg_pid, cfg_pid_en,
    input  pcr_o_valid, pcr_o_data, pcr_o_pid, pcr_o_disc, pcr_o_stamp, sync_err
  );

  modport slave (
    input  ts_sync, ts_valid, ts_data, cfg_pid, cfg_pid_en,
    output pcr_o_valid, pcr_o_data, pcr_o_pid, pcr_o_disc, pcr_o_stamp, sync_err
  );

endinterface

// File: rtl/pcr_local_clk.sv
// pcr_local_clk: free-running 27 MHz PCR-format clock (33-bit base, 9-bit ext 0..299).
//   clk, rst (async, active-low)
//   i_load / i_load_val : synchronous preset of {base, ext}
//   o_pcr_clk           : {base, ext}
module pcr_local_clk
  import ts_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [PCR_W-1:0] i_load_val,
  output logic [PCR_W-1:0] o_pcr_clk
);

  logic [PCR_BASE_W-1:0] r_base;
  logic [PCR_EXT_W-1:0]  r_ext;

  // ext rolls over at PCR_EXT_MAX and carries into base; base wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base <= '0;
      r_ext  <= '0;
    end else if (i_load) begin
      r_base <= i_load_val[PCR_W-1:PCR_EXT_W];
      r_ext  <= i_load_val[PCR_EXT_W-1:0];
    end else if (r_ext == PCR_EXT_W'(PCR_EXT_MAX)) begin
      r_ext  <= '0;
      r_base <= r_base + PCR_BASE_W'(1);
    end else begin
      r_ext  <= r_ext + PCR_EXT_W'(1);
    end
  end

  assign o_pcr_clk = {r_base, r_ext};

endmodule

// File: rtl/pcr_extract.sv
// pcr_extract: parses a byte-wide TS stream, pulls the adaptation-field PCR of the
// selected PID and reports it with the local clock sampled at that packet's sync byte.
//   clk, rst (async, active-low)
//   bus.ts_*            : TS byte stream (sync/valid/data)
//   bus.cfg_pid(_en)    : PID filter, latched at each good sync byte
//   bus.pcr_o_*         : PCR, PID, discontinuity flag, arrival stamp + one-cycle valid
//   bus.sync_err        : one-cycle pulse on a sync-flagged byte that is not 8'h47
module pcr_extract
  import ts_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  pcr_extract_if.slave bus
);

  logic [PCR_W-1:0] w_lclk;
  logic [7:0]       w_byte;
  logic             w_pid_miss;

  pcr_state_t       r_state;
  logic [7:0]       r_byte_cnt;   // offset of the next byte to be accepted
  logic [PCR_W-1:0] r_stamp;
  logic [PID_W-1:0] r_cfg_pid;
  logic             r_cfg_en;
  logic             r_tei;
  logic [PID_W-1:0] r_pid;
  logic             r_disc;
  logic [39:0]      r_pcr_sr;     // PCR bytes 6..10; byte 11 joins on the fly

  logic             r_o_valid;
  logic [PCR_W-1:0] r_o_data;
  logic [PID_W-1:0] r_o_pid;
  logic             r_o_disc;
  logic [PCR_W-1:0] r_o_stamp;
  logic             r_sync_err;

  pcr_local_clk u_lclk (
    .clk        (clk),
    .rst        (rst),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_pcr_clk  (w_lclk)
  );

  assign w_byte     = bus.ts_data;
  assign w_pid_miss = r_cfg_en && (r_pid != r_cfg_pid);

  // Packet parser; a sync-flagged byte always restarts at offset 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_byte_cnt <= '0;
      r_stamp    <= '0;
      r_cfg_pid  <= '0;
      r_cfg_en   <= 1'b0;
      r_tei      <= 1'b0;
      r_pid      <= '0;
      r_disc     <= 1'b0;
      r_pcr_sr   <= '0;
      r_o_valid  <= 1'b0;
      r_o_data   <= '0;
      r_o_pid    <= '0;
      r_o_disc   <= 1'b0;
      r_o_stamp  <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_o_valid  <= 1'b0;
      r_sync_err <= 1'b0;
      if (bus.ts_valid) begin
        if (bus.ts_sync) begin
          if (w_byte == TS_SYNC_BYTE) begin
            r_stamp    <= w_lclk;
            r_cfg_pid  <= bus.cfg_pid;
            r_cfg_en   <= bus.cfg_pid_en;
            r_byte_cnt <= 8'(PID_HI);
            r_state    <= HDR;
          end else begin
            r_sync_err <= 1'b1;
            r_state    <= IDLE;
          end
        end else if (r_state != IDLE) begin
          r_byte_cnt <= r_byte_cnt + 8'd1;
          case (r_state)
            HDR: begin
              if (r_byte_cnt == 8'(PID_HI)) begin
                r_tei              <= w_byte[7];
                r_pid[PID_W-1:8]   <= w_byte[4:0];
              end else if (r_byte_cnt == 8'(PID_LO)) begin
                r_pid[7:0]         <= w_byte;
              end else if (r_byte_cnt == 8'(AFC)) begin
                // afc[1] set means an adaptation field is present
                r_state <= (r_tei || !w_byte[5] || w_pid_miss) ? SKIP : AF;
              end
            end
            AF: begin
              if (r_byte_cnt == 8'(AF_LEN)) begin
                if (w_byte < 8'(PCR_AF_MIN_LEN)) r_state <= SKIP;
              end else if (r_byte_cnt == 8'(AF_FLAGS)) begin
                r_disc  <= w_byte[7];
                r_state <= w_byte[4] ? PCR : SKIP;
              end
            end
            PCR: begin
              if (r_byte_cnt < 8'(PCR_LAST)) begin
                r_pcr_sr <= {r_pcr_sr[31:0], w_byte};
              end else if (r_byte_cnt == 8'(PCR_LAST)) begin
                // base = bytes 6..9 + byte10[7]; ext = byte10[0] + byte 11
                r_o_valid <= 1'b1;
                r_o_data  <= {r_pcr_sr[39:8], r_pcr_sr[7], r_pcr_sr[0], w_byte};
                r_o_pid   <= r_pid;
                r_o_disc  <= r_disc;
                r_o_stamp <= r_stamp;
              end
            end
            default: ;
          endcase
          if (r_byte_cnt == 8'(TS_PKT_LEN - 1)) r_state <= IDLE;
        end
      end
    end
  end

  assign bus.pcr_o_valid = r_o_valid;
  assign bus.pcr_o_data  = r_o_data;
  assign bus.pcr_o_pid   = r_o_pid;
  assign bus.pcr_o_disc  = r_o_disc;
  assign bus.pcr_o_stamp = r_o_stamp;
  assign bus.sync_err    = r_sync_err;

endmodule

// File: tb/tb_pcr_extract.sv
// Randomized bench for pcr_extract with a packet-level reference model.
module tb_pcr_extract;
  import ts_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pcr_extract_if bus ();

  pcr_extract dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Standalone local clock instance for preset/wrap checks
  logic        lc_load = 1'b0;
  logic [41:0] lc_val  = '0;
  logic [41:0] lc_out;
  pcr_local_clk u_lc (
    .clk        (clk),
    .rst        (rst),
    .i_load     (lc_load),
    .i_load_val (lc_val),
    .o_pcr_clk  (lc_out)
  );

  int n_checks = 0;
  int n_err    = 0;
  int pulses   = 0;
  int serrs    = 0;
  longint ticks;

  // Cycles elapsed since reset release: the local clock in raw 27 MHz ticks
  always @(posedge clk or negedge rst)
    if (!rst) ticks <= 0;
    else      ticks <= ticks + 1;

  always @(negedge clk) begin
    if (bus.pcr_o_valid) pulses++;
    if (bus.sync_err)    serrs++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] ticks_to_pcr(input longint t);
    return {33'(t / 300), 9'(t % 300)};
  endfunction

  // Reference: what one (possibly truncated) packet should produce
  task automatic model(input logic [7:0] p [188], input int n, input logic [12:0] cpid,
                       input logic en, output bit ok, output logic [41:0] pcr,
                       output logic [12:0] pid, output logic disc);
    logic [32:0] base;
    logic [8:0]  ext;
    pid  = {p[1][4:0], p[2]};
    disc = p[5][7];
    base = {p[6], p[7], p[8], p[9], p[10][7]};
    ext  = {p[10][0], p[11]};
    pcr  = {base, ext};
    ok   = (n >= 12) && (p[0] == 8'h47) && !p[1][7] && p[3][5]
           && !(en && pid != cpid) && (p[4] >= 8'd7) && p[5][4];
  endtask

  task automatic build_pkt(output logic [7:0] p [188], input logic [12:0] pid, input logic tei,
                           input logic [1:0] afc, input logic [7:0] aflen,
                           input logic [7:0] flags, input logic [47:0] pcr);
    for (int i = 0; i < 188; i++) p[i] = 8'($urandom);
    p[0] = 8'h47;
    p[1] = {tei, 2'b00, pid[12:8]};
    p[2] = pid[7:0];
    p[3] = {2'b00, afc, 4'($urandom)};
    p[4] = aflen;
    p[5] = flags;
    for (int k = 0; k < 6; k++) p[6+k] = pcr[47-8*k -: 8];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.ts_valid = 1'b0;
      bus.ts_sync  = 1'($urandom);
      bus.ts_data  = 8'($urandom);
    end
  endtask

  task automatic drive_byte(input logic s, input logic [7:0] d, input bit gaps);
    if (gaps) idle($urandom_range(0, 2));
    @(negedge clk);
    bus.ts_valid = 1'b1;
    bus.ts_sync  = s;
    bus.ts_data  = d;
  endtask

  task automatic run_pkt(input string tag, input logic [7:0] p [188], input int n,
                         input logic [12:0] cpid, input logic en, input bit gaps);
    int p0, s0;
    longint t0;
    bit ok;
    logic [41:0] epcr;
    logic [12:0] epid;
    logic edisc;
    bus.cfg_pid    = cpid;
    bus.cfg_pid_en = en;
    p0 = pulses;
    s0 = serrs;
    t0 = 0;
    for (int i = 0; i < n; i++) begin
      drive_byte(i == 0, p[i], gaps && i != 0);
      if (i == 0) t0 = ticks;
      // Config changes after the sync byte must not affect this packet
      if (i == 1) begin
        bus.cfg_pid    = 13'($urandom);
        bus.cfg_pid_en = 1'($urandom);
      end
    end
    idle(3);
    model(p, n, cpid, en, ok, epcr, epid, edisc);
    check({tag, ".pulse"}, 64'(pulses - p0), 64'(ok));
    check({tag, ".serr"}, 64'(serrs - s0), 64'(p[0] != 8'h47));
    if (ok) begin
      check({tag, ".data"},  64'(bus.pcr_o_data),  64'(epcr));
      check({tag, ".pid"},   64'(bus.pcr_o_pid),   64'(epid));
      check({tag, ".disc"},  64'(bus.pcr_o_disc),  64'(edisc));
      check({tag, ".stamp"}, 64'(bus.pcr_o_stamp), 64'(ticks_to_pcr(t0)));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".valid"}, 64'(bus.pcr_o_valid), 64'd0);
    check({tag, ".data"},  64'(bus.pcr_o_data),  64'd0);
    check({tag, ".pid"},   64'(bus.pcr_o_pid),   64'd0);
    check({tag, ".disc"},  64'(bus.pcr_o_disc),  64'd0);
    check({tag, ".stamp"}, 64'(bus.pcr_o_stamp), 64'd0);
    check({tag, ".serr"},  64'(bus.sync_err),    64'd0);
  endtask

  localparam logic [47:0] PCR_BYTES = 48'h1234_5678_FF9A;
  localparam logic [41:0] PCR_EXP   = {33'h0_2468_ACF1, 9'h19A};
  localparam logic [41:0] STAMP_EXP = {33'd5, 9'd299};

  initial begin
    logic [7:0] pkt  [188];
    logic [7:0] pkt2 [188];
    int p0;
    bus.ts_valid   = 1'b0;
    bus.ts_sync    = 1'b0;
    bus.ts_data    = '0;
    bus.cfg_pid    = '0;
    bus.cfg_pid_en = 1'b0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;

    // Sync sampled with the local clock at base=5, ext=299, gapped bytes
    while (ticks < 1798) @(negedge clk);
    build_pkt(pkt, 13'h100, 1'b0, 2'b11, 8'd7, 8'h10, PCR_BYTES);
    run_pkt("basic", pkt, 188, 13'h100, 1'b1, 1'b1);
    check("basic.data_const",  64'(bus.pcr_o_data),  64'(PCR_EXP));
    check("basic.stamp_const", 64'(bus.pcr_o_stamp), 64'(STAMP_EXP));

    run_pkt("pid_miss", pkt, 188, 13'h101, 1'b1, 1'b0);
    run_pkt("pid_any",  pkt, 188, 13'h101, 1'b0, 1'b1);

    build_pkt(pkt, 13'h100, 1'b1, 2'b11, 8'd7, 8'h10, PCR_BYTES);
    run_pkt("tei", pkt, 188, 13'h100, 1'b1, 1'b0);
    build_pkt(pkt, 13'h100, 1'b0, 2'b01, 8'd7, 8'h10, PCR_BYTES);
    run_pkt("afc01", pkt, 188, 13'h100, 1'b1, 1'b0);
    build_pkt(pkt, 13'h100, 1'b0, 2'b11, 8'd0, 8'h10, PCR_BYTES);
    run_pkt("aflen0", pkt, 188, 13'h100, 1'b1, 1'b0);
    build_pkt(pkt, 13'h100, 1'b0, 2'b11, 8'd7, 8'h00, PCR_BYTES);
    run_pkt("noflag", pkt, 188, 13'h100, 1'b1, 1'b0);
    build_pkt(pkt, 13'h100, 1'b0, 2'b11, 8'd7, 8'h90, PCR_BYTES);
    run_pkt("disc", pkt, 188, 13'h100, 1'b1, 1'b1);
    check("disc.const", 64'(bus.pcr_o_disc), 64'd1);

    // Bad sync byte
    build_pkt(pkt, 13'h100, 1'b0, 2'b11, 8'd7, 8'h10, PCR_BYTES);
    pkt[0] = 8'h46;
    run_pkt("badsync", pkt, 188, 13'h100, 1'b1, 1'b0);

    // Packet cut off by a new sync at byte 8, then a clean packet
    build_pkt(pkt, 13'h0AB, 1'b0, 2'b11, 8'd9, 8'h10, 48'($urandom) << 16);
    run_pkt("trunc", pkt, 8, 13'h0AB, 1'b1, 1'b0);
    build_pkt(pkt2, 13'h0AB, 1'b0, 2'b10, 8'd20, 8'h10, {16'($urandom), 32'($urandom)});
    run_pkt("after_trunc", pkt2, 188, 13'h0AB, 1'b1, 1'b1);

    // Reset asserted at byte 9 of a PCR packet
    p0 = pulses;
    build_pkt(pkt, 13'h100, 1'b0, 2'b11, 8'd7, 8'h10, PCR_BYTES);
    bus.cfg_pid    = 13'h100;
    bus.cfg_pid_en = 1'b1;
    for (int i = 0; i < 9; i++) drive_byte(i == 0, pkt[i], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.ts_valid = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    rst = 1'b1;
    idle(20);
    check("midreset.no_pulse", 64'(pulses - p0), 64'd0);
    run_pkt("post_reset", pkt, 188, 13'h100, 1'b1, 1'b1);

    // Randomized packets
    for (int r = 0; r < 40; r++) begin
      logic [12:0] cpid;
      logic [12:0] pid;
      logic [7:0]  aflen;
      logic [7:0]  flags;
      cpid  = 13'($urandom);
      pid   = ($urandom_range(0, 3) == 0) ? 13'($urandom) : cpid;
      aflen = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(7, 183))
                                          : 8'($urandom_range(0, 10));
      flags = 8'($urandom);
      if ($urandom_range(0, 3) != 0) flags[4] = 1'b1;
      build_pkt(pkt, pid, ($urandom_range(0, 7) == 0), 2'($urandom), aflen, flags,
                {16'($urandom), 32'($urandom)});
      run_pkt($sformatf("rnd%0d", r), pkt, 188, cpid, ($urandom_range(0, 4) != 0),
              1'($urandom));
    end

    // Local clock preset and wrap behaviour
    @(negedge clk);
    lc_load = 1'b1;
    lc_val  = {33'd5, 9'd299};
    @(negedge clk);
    lc_load = 1'b0;
    check("lclk.preset", 64'(lc_out), 64'({33'd5, 9'd299}));
    @(negedge clk);
    check("lclk.ext_carry", 64'(lc_out), 64'({33'd6, 9'd0}));
    lc_load = 1'b1;
    lc_val  = {33'h1_FFFF_FFFF, 9'd299};
    @(negedge clk);
    lc_load = 1'b0;
    check("lclk.max", 64'(lc_out), 64'({33'h1_FFFF_FFFF, 9'd299}));
    @(negedge clk);
    check("lclk.wrap", 64'(lc_out), 64'd0);
    @(negedge clk);
    check("lclk.after_wrap", 64'(lc_out), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pcr_extract.md
# pcr_extract

Receive-side PCR reader for the IPQAM TS path: parses a byte-wide MPEG-TS stream (sync/valid/data), locates the adaptation-field PCR of a selected PID, and emits the 42-bit PCR together with a local 27 MHz arrival timestamp. It is the reading counterpart of the delay/PCR-rewrite stage. Its output pair (PCR, arrival stamp) feeds the PCR correction arithmetic that produces the 42-bit corrected value written back into the stream downstream.

## Interface
- U_DLY, 1, simulation-only register delay
- PCR_EXT_MAX, 299, last value of the 9-bit PCR extension before base increments
- clk  input  1  system clock, 27 MHz nominal
- rst  input  1  asynchronous, active-low reset (0 = reset)
- ts_sync  input  1  high with byte 0 of a packet; only meaningful when ts_valid=1
- ts_valid  input  1  byte qualifier
- ts_data  input  8  TS byte
- cfg_pid  input  13  PID to extract PCR from
- cfg_pid_en  input  1  1 = filter on cfg_pid; 0 = accept PCR from any PID
- pcr_o_valid  output  1  one-cycle pulse, PCR fields valid
- pcr_o_data  output  42  [41:9] = 33-bit base, [8:0] = 9-bit extension
- pcr_o_pid  output  13  PID of the packet carrying the PCR
- pcr_o_disc  output  1  discontinuity_indicator of that packet
- pcr_o_stamp  output  42  local clock at that packet's sync byte, same format as pcr_o_data
- sync_err  output  1  one-cycle pulse: sync-flagged byte not equal to 8'h47

## Operation
- All outputs reset to 0; the local clock resets to base=0, ext=0.
- Local clock: ext increments every clk; at ext=PCR_EXT_MAX it returns to 0 and base increments. Base wraps 2^33-1 -> 0.
- Bytes are consumed only when ts_valid=1. byte_cnt: sync byte = 0; 1..187 follow.
- Sync byte with data=8'h47: latch the local clock into the stamp register, latch cfg_pid/cfg_pid_en, go to HDR.
- Sync byte with data≠8'h47: pulse sync_err, go to IDLE.
- A sync byte arriving at any byte_cnt restarts parsing at byte 0; the partial packet is dropped with no output.
- FSM states: IDLE, HDR, AF, PCR, SKIP.
  - IDLE: wait for a sync byte.
  - HDR: byte 1 captures TEI (bit7) and PID[12:8]. Byte 2 captures PID[7:0]. Byte 3 captures adaptation_field_control [5:4].
    - After byte 3, go to SKIP if any of: TEI=1, afc[1]=0, or (cfg_pid_en=1 and PID≠latched cfg_pid). Otherwise go to AF.
  - AF: byte 4 = AF length; if < 7, go to SKIP. Byte 5 captures disc (bit7) and PCR_flag (bit4); if PCR_flag=0, go to SKIP.
  - PCR: bytes 6..11 shift in big-endian. Byte 10 supplies base[0]=bit7 and ext[8]=bit0; bits 6:1 are ignored.
  - SKIP: count to byte 187, then go to IDLE.
- After byte 187 of a PCR packet, go to IDLE.

## Timing
- pcr_o_valid pulses in the cycle after byte 11 is accepted. pcr_o_data/pid/disc/stamp update in that same cycle and hold until the next pulse.
- pcr_o_stamp reflects the local clock value in the cycle the sync byte is sampled.
- sync_err pulses in the cycle after the bad sync byte.
- ts_valid gaps stall the parser at any byte; no timeout.
- Reset asserted mid-packet: FSM goes to IDLE, outputs go to 0, and no pulse is emitted for that packet.
- A cfg_pid change mid-packet takes effect at the next sync byte.

## Structure
- Shared package `ts_pkg`:
  - TS_PKT_LEN=188, TS_SYNC_BYTE=8'h47
  - byte offsets: PID_HI=1, PID_LO=2, AFC=3, AF_LEN=4, AF_FLAGS=5, PCR_FIRST=6, PCR_LAST=11
  - PCR_EXT_MAX
  - FSM state encoding
- Sub-module `pcr_local_clk`: the base/ext 27 MHz counter with 42-bit output. It is reused by the correction stage.

## Test plan
- PID 0x100 packet, AF len 7, flags 0x10, PCR bytes 12 34 56 78 FF 9A; cfg_pid=0x100, en=1 -> one pulse, pcr_o_data = {33'h02468ACF1, 9'h19A}, disc=0, pid=0x100.
- Same packet with cfg_pid=0x101 -> no pulse. Repeat with en=0 -> pulse.
- TEI=1, or afc=01, or AF length 0, or PCR_flag=0 -> no pulse. Flags 0x90 -> pcr_o_disc=1.
- Sync sampled at local clock base=5, ext=299 with random ts_valid gaps -> stamp = {33'd5, 9'd299}; base increments on the following cycle.
- Sync byte 0x46 -> sync_err pulse, no PCR. A new sync at byte 8 of a PCR packet -> that packet is dropped and the new packet parses correctly.
- Force base to 2^33-1, ext=299 -> next cycle reads 0/0. Assert reset at byte 9 -> outputs 0 and no pulse.
